// File: rtl/cpu_pkg.sv
// Opcode constants shared by the memory, pc and execute stages.
package cpu_pkg;

    localparam logic [3:0] OP_CLEAR_LOAD  = 4'b0000;
    localparam logic [3:0] OP_ADD_LOAD    = 4'b0001;
    localparam logic [3:0] OP_ADD         = 4'b0010;
    localparam logic [3:0] OP_SHIFT_RIGHT = 4'b0011;
    localparam logic [3:0] OP_DISP        = 4'b0100;

endpackage

// File: rtl/adder_w.sv
// WIDTH-bit adder with carry-out, used for the upper half of the product.
module adder_w #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/execute_unit.sv
// Shift-add multiplier execute stage driven one opcode per enabled cycle.
// Optional step counter / done flag: define EXECUTE_STEP_COUNT_EN.
module execute_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 en,
    input  logic [3:0]           opcode,
    input  logic [WIDTH-1:0]     data,
    output logic [2*WIDTH-1:0]   product,
    output logic [2*WIDTH-1:0]   result,
    output logic                 result_valid,
    output logic                 illegal,
    output logic                 done
);

    logic [2*WIDTH-1:0] p;
    logic               c;
    logic [WIDTH-1:0]   sum;
    logic               cout;

    adder_w #(.WIDTH(WIDTH)) u_adder (
        .a     (p[2*WIDTH-1:WIDTH]),
        .b     (data),
        .sum   (sum),
        .carry (cout)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            p            <= '0;
            c            <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            illegal      <= 1'b0;
            if (en) begin
                case (opcode)
                    OP_CLEAR_LOAD: begin
                        p <= '0;
                        c <= 1'b0;
                    end
                    OP_ADD_LOAD: begin
                        p <= {{WIDTH{1'b0}}, data};
                        c <= 1'b0;
                    end
                    OP_ADD: begin
                        // Only add when the current multiplier bit is set.
                        if (p[0]) begin
                            p <= {sum, p[WIDTH-1:0]};
                            c <= cout;
                        end else begin
                            c <= 1'b0;
                        end
                    end
                    OP_SHIFT_RIGHT: begin
                        p <= {c, p[2*WIDTH-1:1]};
                        c <= 1'b0;
                    end
                    OP_DISP: begin
                        result       <= p;
                        result_valid <= 1'b1;
                    end
                    default: illegal <= 1'b1;
                endcase
            end
        end
    end

    assign product = p;

`ifdef EXECUTE_STEP_COUNT_EN
    localparam int NW = $clog2(WIDTH) + 1;
    logic [NW-1:0] n;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            n <= '0;
        end else if (en) begin
            case (opcode)
                OP_CLEAR_LOAD, OP_ADD_LOAD: n <= '0;
                OP_SHIFT_RIGHT: if (n != NW'(WIDTH)) n <= n + 1'b1;
                default: ;
            endcase
        end
    end

    assign done = (n == NW'(WIDTH));
`else
    assign done = 1'b0;
`endif

endmodule

// File: tb/tb_execute_unit.sv
// Self-checking bench: directed multiply sequences plus random opcode stream vs. an arithmetic model.
module tb_execute_unit;

    localparam int W = 4;

    logic             clock;
    logic             reset;
    logic             en;
    logic [3:0]       opcode;
    logic [W-1:0]     data;
    logic [2*W-1:0]   product;
    logic [2*W-1:0]   result;
    logic             result_valid;
    logic             illegal;
    logic             done;

    int n_tests = 0;
    int n_fail  = 0;

    // reference state
    int unsigned mp, mc, mn, m_res, m_rv, m_ill;

    execute_unit #(.WIDTH(W)) dut (
        .clock        (clock),
        .reset        (reset),
        .en           (en),
        .opcode       (opcode),
        .data         (data),
        .product      (product),
        .result       (result),
        .result_valid (result_valid),
        .illegal      (illegal),
        .done         (done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned exp_done();
`ifdef EXECUTE_STEP_COUNT_EN
        return (mn == W) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        mp = 0; mc = 0; mn = 0; m_res = 0; m_rv = 0; m_ill = 0;
    endtask

    // Multiplier semantics written as integer arithmetic on the 2W-bit product.
    task automatic model_step(input int unsigned e, input int unsigned o, input int unsigned d);
        int unsigned s;
        m_rv = 0; m_ill = 0;
        if (e != 0) begin
            case (o)
                0: begin mp = 0; mc = 0; mn = 0; end
                1: begin mp = d; mc = 0; mn = 0; end
                2: if (mp % 2 == 1) begin
                       s  = (mp >> W) + d;
                       mc = s >> W;
                       mp = ((s % (1 << W)) << W) + (mp % (1 << W));
                   end else mc = 0;
                3: begin
                       mp = (mc << (2*W-1)) + (mp >> 1);
                       mc = 0;
                       if (mn < W) mn++;
                   end
                4: begin m_res = mp; m_rv = 1; end
                default: m_ill = 1;
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".product"}, product, mp);
        chk({tag, ".result"}, result, m_res);
        chk({tag, ".valid"}, result_valid, m_rv);
        chk({tag, ".illegal"}, illegal, m_ill);
        chk({tag, ".done"}, done, exp_done());
    endtask

    // Called at a negedge; drives for the next posedge and checks at the following negedge.
    task automatic issue(input logic e, input logic [3:0] o, input logic [W-1:0] d, input string tag);
        en = e; opcode = o; data = d;
        @(negedge clock);
        model_step(e, o, d);
        check_all(tag);
    endtask

    task automatic multiply(input int unsigned a, input int unsigned b, input string tag);
        issue(1, 4'd0, '0, {tag, ".clr"});
        issue(1, 4'd1, W'(a), {tag, ".ld"});
        for (int i = 0; i < W; i++) begin
            issue(1, 4'd2, W'(b), {tag, ".add"});
            issue(1, 4'd3, '0, {tag, ".shr"});
        end
        issue(1, 4'd4, '0, {tag, ".disp"});
        chk({tag, ".mul"}, result, a * b);
        chk({tag, ".pulse"}, result_valid, 1);
`ifdef EXECUTE_STEP_COUNT_EN
        chk({tag, ".done"}, done, 1);
`endif
        issue(0, 4'd0, '0, {tag, ".idle"});
        chk({tag, ".pulse_end"}, result_valid, 0);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; opcode = '0; data = '0;
        model_reset();
        #2;
        check_all("reset");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        multiply(3, 5, "m3x5");
        multiply(15, 15, "m15x15");

        issue(1, 4'd5, '0, "illegal");
        chk("illegal.pulse", illegal, 1);
        issue(0, 4'd0, '0, "illegal.after");
        chk("illegal.drop", illegal, 0);

        issue(0, 4'd1, W'(7), "en0");
        chk("en0.product", product, 8'hE1);

        // reset between edges after the second shift
        issue(1, 4'd0, '0, "rst.clr");
        issue(1, 4'd1, W'(3), "rst.ld");
        issue(1, 4'd2, W'(5), "rst.add0");
        issue(1, 4'd3, '0, "rst.shr0");
        issue(1, 4'd2, W'(5), "rst.add1");
        issue(1, 4'd3, '0, "rst.shr1");
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("rst.async");
        @(negedge clock);
        reset = 1'b0;
        multiply(2, 3, "m2x3");

        issue(1, 4'd4, '0, "disp2.a");
        issue(1, 4'd4, '0, "disp2.b");
        chk("disp2.valid", result_valid, 1);
        chk("disp2.result", result, 8'h06);
        issue(0, 4'd0, '0, "disp2.end");

        for (int i = 0; i < 400; i++) begin
            int unsigned r;
            logic [3:0] o;
            r = $urandom_range(0, 99);
            if (r < 8)       o = 4'(0);
            else if (r < 18) o = 4'(1);
            else if (r < 50) o = 4'(2);
            else if (r < 80) o = 4'(3);
            else if (r < 90) o = 4'(4);
            else             o = 4'($urandom_range(5, 15));
            issue(($urandom_range(0, 9) < 8), o, W'($urandom), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/execute_unit.md
EXECUTE_UNIT -- requirements
Module: execute_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, operand width; the product is 2*WIDTH bits.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port en  input  1  instruction strobe; opcode/data are executed only in cycles where en=1.
REQ-005 SHALL have port opcode  input  4  instruction code from the instruction memory stage.
REQ-006 SHALL have port data  input  WIDTH  operand accompanying opcode.
REQ-007 SHALL have port product  output  2*WIDTH  live product register P.
REQ-008 SHALL have port result  output  2*WIDTH  P value latched by DISP.
REQ-009 SHALL have port result_valid  output  1  one-cycle pulse in the cycle after a DISP executes.
REQ-010 SHALL have port illegal  output  1  one-cycle pulse in the cycle after an undefined opcode is executed.
REQ-011 SHALL have port done  output  1  high once WIDTH shifts have completed (see Configuration).

Function
REQ-012 SHALL hold internal state: P (2*WIDTH), carry C (1), and, with the macro defined, shift counter N (clog2(WIDTH)+1 bits).
REQ-013 SHALL execute 0000 CLEAR_LOAD as: P<=0, C<=0, N<=0.
REQ-014 SHALL execute 0001 ADD_LOAD as: P<={0,data} (multiplier in low half), C<=0, N<=0.
REQ-015 SHALL execute 0010 ADD as: if P[0]=1 then {C,P[2W-1:W]}<=P[2W-1:W]+data (W+1-bit sum, carry captured); else P unchanged and C<=0.
REQ-016 SHALL execute 0011 SHIFT_RIGHT as: P<={C,P[2W-1:1]}, C<=0; N increments and saturates at WIDTH.
REQ-017 SHALL execute 0100 DISP as: result<=P, with result_valid high for exactly the following cycle; P, C and N unchanged.
REQ-018 SHALL treat opcodes 0101-1111 as no-ops on P, C and N, and pulse illegal for one cycle.
REQ-019 SHALL have a latency of one cycle: the effect of an instruction sampled at edge k is visible on the outputs after edge k.
REQ-020 SHALL, when en=0, change no state and drive result_valid=0 and illegal=0.
REQ-021 SHALL hold result between DISPs; back-to-back DISPs produce a pulse in each cycle.
REQ-022 SHALL discard the carry out of the upper half on SHIFT_RIGHT past bit 2W-1; no overflow flag is generated.
REQ-023 SHALL contain no internal FSM beyond the opcode decode; the upstream pc sequencer owns ordering.

Reset
REQ-024 SHALL, while reset=1, asynchronously force P=0, C=0, N=0, result=0, result_valid=0, illegal=0 and done=0.
REQ-025 SHALL, on reset asserted mid-sequence, abandon the partial product; the first instruction after release executes normally.

Configuration
REQ-026 SHALL compile counter N and the done logic only when macro EXECUTE_STEP_COUNT_EN is defined; done=1 iff N==WIDTH.
REQ-027 SHALL, without EXECUTE_STEP_COUNT_EN, omit N and tie done to constant 0; all other behaviour is identical.

Structure
REQ-028 SHALL take opcode constants (OP_CLEAR_LOAD, OP_ADD_LOAD, OP_ADD, OP_SHIFT_RIGHT, OP_DISP) from shared package cpu_pkg, which is also used by the memory and pc stages.
REQ-029 SHALL instantiate one sub-module, adder_w (WIDTH-bit adder with carry-out), for the ADD datapath.

Verification
REQ-030 SHALL verify: CLEAR_LOAD; ADD_LOAD 3; then (ADD 5, SHIFT_RIGHT) x4; then DISP -> result=0x0F with a one-cycle result_valid pulse, and done=1 when the macro is defined.
REQ-031 SHALL verify: the same sequence with multiplier 15 and multiplicand 15 -> result=0xE1 (exercises the carry).
REQ-032 SHALL verify: opcode 0101 with en=1 -> illegal pulses for one cycle and product is unchanged.
REQ-033 SHALL verify: en=0 with opcode ADD_LOAD and data 7 -> product is unchanged and no pulses occur.
REQ-034 SHALL verify: reset asserted after the 2nd SHIFT_RIGHT, between clock edges -> all outputs are 0 immediately; restarting with 2*3 yields result=0x06.
REQ-035 SHALL verify: two consecutive DISPs -> result_valid stays high for 2 cycles and result is stable.
